// File: rtl/regbus_wb_bridge.sv
// Wishbone classic slave to single-outstanding reg-bus bridge with address decode
// and ack-timeout watchdog. Optional error logging enabled by REGBUS_ERR_LOG_EN.
module regbus_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [2:0]  LAST_SEL       = 3'b100,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_0BAD
) (
  input  logic        app_clk,
  input  logic        arst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [8:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [8:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack
`ifdef REGBUS_ERR_LOG_EN
  ,
  output logic [8:0]  err_addr_o,
  output logic        err_type_o,
  output logic        err_intr_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [15:0] TERM_CNT    = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]  STATUS_ADDR = 9'h1FC;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic        accept;
  logic        we_q;
  logic [8:0]  adr_q;
  logic [31:0] wdat_q;
  logic [3:0]  sel_q;
  logic        status_hit;
  logic [31:0] status_rdata;

`ifdef REGBUS_ERR_LOG_EN
  logic [8:0] err_addr_q;
  logic       err_type_q;
  logic       err_intr_q;

  // The status address is claimed locally before decode, so it never errors.
  assign status_hit   = (wbs_adr_i == STATUS_ADDR);
  assign status_rdata = {31'b0, err_intr_q};
`else
  assign status_hit   = 1'b0;
  assign status_rdata = '0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = '0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          accept = 1'b1;
          if (status_hit) begin
            state_d = RESP;
            ack_d   = 1'b1;
            dat_d   = status_rdata;
          end else if (wbs_adr_i[8:6] > LAST_SEL) begin
            state_d = RESP;
            err_d   = 1'b1;
            dat_d   = ERR_RDATA;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Master abort beats a same-cycle ack: nobody is left to take the response.
        if (!wbs_cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (reg_ack) begin
          state_d = RESP;
          ack_d   = 1'b1;
          dat_d   = we_q ? 32'h0 : reg_rdata;
        end else if (cnt_q == TERM_CNT) begin
          state_d = RESP;
          err_d   = 1'b1;
          dat_d   = ERR_RDATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      if (accept) begin
        we_q   <= wbs_we_i;
        adr_q  <= wbs_adr_i;
        wdat_q <= wbs_dat_i;
        sel_q  <= wbs_sel_i;
      end
    end
  end

`ifdef REGBUS_ERR_LOG_EN
  // Decode errors log the incoming address; timeouts log the captured one.
  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      err_addr_q <= '0;
      err_type_q <= 1'b0;
      err_intr_q <= 1'b0;
    end else if (err_d) begin
      err_addr_q <= (state_q == REQ) ? adr_q : wbs_adr_i;
      err_type_q <= (state_q == REQ);
      err_intr_q <= 1'b1;
    end else if (accept && status_hit) begin
      err_intr_q <= 1'b0;
    end
  end

  assign err_addr_o = err_addr_q;
  assign err_type_o = err_type_q;
  assign err_intr_o = err_intr_q;
`endif

  assign reg_cs    = (state_q == REQ);
  assign reg_wr    = we_q;
  assign reg_addr  = adr_q;
  assign reg_wdata = wdat_q;
  assign reg_be    = sel_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;

endmodule
